// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin arbiter and transfer sequencer for a single-port RAM.
// All outputs are registered; this block is the only driver of the RAM bus.
module ram_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              wire_clock,
    input  logic              wire_reset,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bus_RAM_ADDRESS,
    output logic [DATA_W-1:0] bus_RAM_DATA_OUT,
    output logic              wire_RW,
    input  logic [DATA_W-1:0] bus_RAM_DATA_IN,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    // WAIT lasts RD_LAT-1 cycles; the counter is loaded with that count minus one.
    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 2);

    state_t     state;
    state_t     state_next;
    logic       prio;
    logic       win;
    logic       capture;
    logic       cur_rw;
    logic [1:0] wait_cnt;

    always_comb begin
        // NOTE: every combinational output is given a default first so no path infers a latch.
        state_next = state;
        capture    = 1'b0;
        win        = (m0_req && m1_req) ? prio : m1_req;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) state_next = ACCESS;
            end
            ACCESS: begin
                if (cur_rw || RD_LAT == 1) begin
                    state_next = DONE;
                    capture    = !cur_rw;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wire_clock or negedge wire_reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!wire_reset) state <= IDLE;
        else             state <= state_next;
    end

    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) begin
            m0_gnt           <= 1'b0;
            m1_gnt           <= 1'b0;
            m0_done          <= 1'b0;
            m1_done          <= 1'b0;
            m0_rdata         <= '0;
            m1_rdata         <= '0;
            bus_RAM_ADDRESS  <= '0;
            bus_RAM_DATA_OUT <= '0;
            wire_RW          <= 1'b0;
            busy             <= 1'b0;
            owner            <= 1'b0;
            prio             <= 1'b0;
            cur_rw           <= 1'b0;
            wait_cnt         <= 2'd0;
        end else begin
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            wire_RW <= 1'b0;
            busy    <= (state_next != IDLE);

            if (state == IDLE && (m0_req || m1_req)) begin
                owner           <= win;
                prio            <= !win;
                m0_gnt          <= !win;
                m1_gnt          <= win;
                cur_rw          <= win ? m1_rw : m0_rw;
                wire_RW         <= win ? m1_rw : m0_rw;
                bus_RAM_ADDRESS <= win ? m1_addr : m0_addr;
                if (win ? m1_rw : m0_rw)
                    bus_RAM_DATA_OUT <= win ? m1_wdata : m0_wdata;
            end

            if (state == ACCESS)    wait_cnt <= WAIT_LOAD;
            else if (state == WAIT) wait_cnt <= wait_cnt - 2'd1;

            // Only the current owner's read-data register is ever written.
            if (capture) begin
                if (owner) m1_rdata <= bus_RAM_DATA_IN;
                else       m0_rdata <= bus_RAM_DATA_IN;
            end

            if (state_next == DONE) begin
                m0_done <= !owner;
                m1_done <= owner;
            end
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: three instances (RD_LAT = 1, 2, 3) share stimulus,
// each with its own RAM model; every phase resets and checks one instance.
module tb_ram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_init;
    logic        m0_req, m0_rw, m1_req, m1_rw;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        gnt0 [3];
    logic        gnt1 [3];
    logic        done0 [3];
    logic        done1 [3];
    logic        ram_rw [3];
    logic        busy [3];
    logic        owner [3];
    logic [15:0] rdata0 [3];
    logic [15:0] rdata1 [3];
    logic [15:0] ram_addr [3];
    logic [15:0] ram_dout [3];
    logic [15:0] ram_din [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] mem [256];
        logic [15:0] pipe [2];

        ram_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(g + 1)) u_dut (
            .wire_clock       (clk),
            .wire_reset       (rst_n),
            .m0_req           (m0_req),
            .m0_rw            (m0_rw),
            .m0_addr          (m0_addr),
            .m0_wdata         (m0_wdata),
            .m0_gnt           (gnt0[g]),
            .m0_done          (done0[g]),
            .m0_rdata         (rdata0[g]),
            .m1_req           (m1_req),
            .m1_rw            (m1_rw),
            .m1_addr          (m1_addr),
            .m1_wdata         (m1_wdata),
            .m1_gnt           (gnt1[g]),
            .m1_done          (done1[g]),
            .m1_rdata         (rdata1[g]),
            .bus_RAM_ADDRESS  (ram_addr[g]),
            .bus_RAM_DATA_OUT (ram_dout[g]),
            .wire_RW          (ram_rw[g]),
            .bus_RAM_DATA_IN  (ram_din[g]),
            .busy             (busy[g]),
            .owner            (owner[g])
        );

        // Unwritten locations read back as 0xA000 | address.
        always @(posedge clk) begin
            if (ram_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
            end else if (ram_rw[g]) begin
                mem[ram_addr[g][7:0]] <= ram_dout[g];
            end
            pipe[0] <= mem[ram_addr[g][7:0]];
            pipe[1] <= pipe[0];
        end

        if (g == 0) begin : g_lat1
            assign ram_din[g] = mem[ram_addr[g][7:0]];
        end else begin : g_latn
            assign ram_din[g] = pipe[g - 1];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        int  xfer;
        int  ph;
        logic own;

        // Reset with both requests high; m0 writes 0xBEEF to 0x0010, m1 reads 0x0010.
        rst_n = 1'b0; ram_init = 1'b1;
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0010; m0_wdata = 16'hBEEF;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 16'h0010; m1_wdata = 16'h0000;
        step(); step(); step();
        check_bit("rst_gnt0",  gnt0[0],  1'b0);
        check_bit("rst_gnt1",  gnt1[0],  1'b0);
        check_bit("rst_done0", done0[0], 1'b0);
        check_bit("rst_done1", done1[0], 1'b0);
        check_bit("rst_rw",    ram_rw[0], 1'b0);
        check_bit("rst_busy",  busy[0],  1'b0);
        check_bit("rst_owner", owner[0], 1'b0);
        check("rst_addr",   ram_addr[0], 16'h0000);
        check("rst_dout",   ram_dout[0], 16'h0000);
        check("rst_rdata0", rdata0[0],   16'h0000);
        check("rst_rdata1", rdata1[0],   16'h0000);

        ram_init = 1'b0; rst_n = 1'b1;
        step();
        check_bit("wr_gnt0",  gnt0[0],  1'b1);
        check_bit("wr_gnt1",  gnt1[0],  1'b0);
        check_bit("wr_rw",    ram_rw[0], 1'b1);
        check_bit("wr_owner", owner[0], 1'b0);
        check_bit("wr_busy",  busy[0],  1'b1);
        check("wr_addr", ram_addr[0], 16'h0010);
        check("wr_dout", ram_dout[0], 16'hBEEF);
        step();
        check_bit("wr_done0", done0[0], 1'b1);
        check_bit("wr_rw_off", ram_rw[0], 1'b0);
        check_bit("wr_gnt0_off", gnt0[0], 1'b0);
        check("wr_addr_hold", ram_addr[0], 16'h0010);
        m0_req = 1'b0;
        step();
        check_bit("idle_done0", done0[0], 1'b0);
        check_bit("idle_busy",  busy[0],  1'b0);
        step();
        check_bit("rd1_gnt1",  gnt1[0],  1'b1);
        check_bit("rd1_owner", owner[0], 1'b1);
        check_bit("rd1_rw",    ram_rw[0], 1'b0);
        step();
        check_bit("rd1_done1", done1[0], 1'b1);
        check("rd1_rdata1", rdata1[0], 16'hBEEF);
        check("rd1_rdata0", rdata0[0], 16'h0000);
        m1_req = 1'b0;

        // RD_LAT = 3: m0 reads 0x0020, then m1 reads back 0xBEEF from 0x0010.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1; m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0020;
        step();
        check_bit("l3_gnt0", gnt0[2], 1'b1);
        check("l3_addr0", ram_addr[2], 16'h0020);
        step();
        check_bit("l3_w1_done0", done0[2], 1'b0);
        check_bit("l3_w1_rw",    ram_rw[2], 1'b0);
        step();
        check_bit("l3_w2_done0", done0[2], 1'b0);
        step();
        check_bit("l3_done0",  done0[2], 1'b1);
        check("l3_rdata0", rdata0[2], 16'hA020);
        m0_req = 1'b0; m1_req = 1'b1;
        step();
        check_bit("l3_idle_busy", busy[2], 1'b0);
        step();
        check_bit("l3_gnt1",  gnt1[2],  1'b1);
        check_bit("l3_owner", owner[2], 1'b1);
        check_bit("l3_rw_a",  ram_rw[2], 1'b0);
        step();
        check_bit("l3_rw_w1", ram_rw[2], 1'b0);
        step();
        check_bit("l3_w2_done1", done1[2], 1'b0);
        check_bit("l3_rw_w2",    ram_rw[2], 1'b0);
        step();
        check_bit("l3_done1", done1[2], 1'b1);
        check("l3_rdata1", rdata1[2], 16'hBEEF);
        check("l3_rdata0_keep", rdata0[2], 16'hA020);
        m1_req = 1'b0;

        // Round robin on RD_LAT = 1 with both requests held for four transfers.
        rst_n = 1'b0;
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0040; m0_wdata = 16'h5555;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 16'h0041;
        step(); step();
        rst_n = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            xfer = (c - 1) / 3;
            ph   = (c - 1) % 3;
            own  = xfer[0];
            check_bit($sformatf("rr%0d_gnt0", c),  gnt0[0],  ph == 0 && !own);
            check_bit($sformatf("rr%0d_gnt1", c),  gnt1[0],  ph == 0 && own);
            check_bit($sformatf("rr%0d_done0", c), done0[0], ph == 1 && !own);
            check_bit($sformatf("rr%0d_done1", c), done1[0], ph == 1 && own);
            check_bit($sformatf("rr%0d_busy", c),  busy[0],  ph != 2);
            check_bit($sformatf("rr%0d_owner", c), owner[0], own);
            check_bit($sformatf("rr%0d_rw", c),    ram_rw[0], ph == 0 && !own);
            if (ph == 1 && own) check($sformatf("rr%0d_rdata1", c), rdata1[0], 16'hA041);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step(); step();
        check_bit("rr_end_gnt0", gnt0[0], 1'b0);
        check_bit("rr_end_gnt1", gnt1[0], 1'b0);
        check_bit("rr_end_busy", busy[0], 1'b0);

        // RD_LAT = 2: m0 drops req and changes addr/rw during WAIT.
        rst_n = 1'b0;
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0050;
        step(); step();
        rst_n = 1'b1;
        step();
        check_bit("l2_gnt0", gnt0[1], 1'b1);
        check("l2_addr", ram_addr[1], 16'h0050);
        step();
        check_bit("l2_wait_done0", done0[1], 1'b0);
        check_bit("l2_wait_busy",  busy[1],  1'b1);
        m0_req = 1'b0; m0_addr = 16'h0060; m0_rw = 1'b1;
        step();
        check_bit("l2_done0", done0[1], 1'b1);
        check("l2_rdata0", rdata0[1], 16'hA050);
        check("l2_addr_hold", ram_addr[1], 16'h0050);
        check_bit("l2_rw", ram_rw[1], 1'b0);
        step();
        check_bit("l2_idle_busy", busy[1], 1'b0);
        step();
        check_bit("l2_no_regnt", gnt0[1], 1'b0);

        // Reset asserted during a write ACCESS on RD_LAT = 1.
        rst_n = 1'b0;
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0070; m0_wdata = 16'h7777;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 16'h0071;
        step(); step();
        rst_n = 1'b1;
        step();
        check_bit("ar_gnt0", gnt0[0], 1'b1);
        check_bit("ar_rw",   ram_rw[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_bit("ar_rw_async",   ram_rw[0], 1'b0);
        check_bit("ar_busy_async", busy[0],  1'b0);
        check_bit("ar_gnt0_async", gnt0[0],  1'b0);
        m0_req = 1'b0;
        step();
        check_bit("ar_no_done0", done0[0], 1'b0);
        rst_n = 1'b1;
        step();
        check_bit("ar_gnt1",  gnt1[0],  1'b1);
        check_bit("ar_gnt0",  gnt0[0],  1'b0);
        check_bit("ar_owner", owner[0], 1'b1);
        step();
        check_bit("ar_done1",  done1[0], 1'b1);
        check_bit("ar_done0",  done0[0], 1'b0);
        check("ar_rdata1", rdata1[0], 16'hA071);
        m1_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
